// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage between decode and execute.
// Reads two operands from an asynchronous-read register file, bypasses a
// same-cycle writeback, tracks pending destination writes in a scoreboard,
// stalls decode on RAW/WAW hazards and hands operands to execute through a
// registered valid/ready output stage.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int AW     = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_rd_en,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [AW-1:0]     rf_a1,
    output logic [AW-1:0]     rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_a,
    input  logic [DATA_W-1:0] wb_wd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_en,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [2**AW-1:0]  busy
);

    localparam int NREG = 2**AW;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              byp1;
    logic              byp2;
    logic              byp_rd;
    logic              haz1;
    logic              haz2;
    logic              waw;
    logic              accept;
    logic [NREG-1:0]   clr;
    logic [NREG-1:0]   set;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    // Resolve operands (zero register, writeback bypass, register file) and
    // derive hazards, handshake and scoreboard update masks.
    always_comb begin
        byp1   = wb_we && (wb_a == in_rs1);
        byp2   = wb_we && (wb_a == in_rs2);
        byp_rd = wb_we && (wb_a == in_rd);

        op1 = '0;
        if (in_rs1 != '0) begin
            op1 = byp1 ? wb_wd : rf_rd1;
        end
        op2 = '0;
        if (in_rs2 != '0) begin
            op2 = byp2 ? wb_wd : rf_rd2;
        end

        // A writeback landing this cycle resolves the pending write in time.
        haz1 = (in_rs1 != '0) && busy[in_rs1] && !byp1;
        haz2 = (in_rs2 != '0) && busy[in_rs2] && !byp2;
        waw  = in_rd_en && (in_rd != '0) && busy[in_rd] && !byp_rd;

        in_ready = !(haz1 || haz2 || waw) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;

        clr = '0;
        set = '0;
        if (wb_we && (wb_a != '0)) begin
            clr[wb_a] = 1'b1;
        end
        if (accept && in_rd_en && (in_rd != '0)) begin
            set[in_rd] = 1'b1;
        end
    end

    // Output stage: load on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1;
            out_op2   <= op2;
            out_rd    <= in_rd;
            out_rd_en <= in_rd_en;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Scoreboard: writeback clears, newly accepted destination sets (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr) | set;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized + directed bench for operand_fetch with a
// reference model of the register file, pending-write set and output stage.
// Expected transfers are queued at issue and checked by a separate monitor.
module tb_operand_fetch;

    localparam int DATA_W = 16;
    localparam int AW     = 5;
    localparam int CTRL_W = 8;
    localparam int NR     = 32;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [AW-1:0]     rd;
        logic              rd_en;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_rd_en, wb_we, out_valid, out_ready, out_rd_en;
    logic [AW-1:0] in_rs1, in_rs2, in_rd, rf_a1, rf_a2, wb_a, out_rd;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, wb_wd, out_op1, out_op2;
    logic [NR-1:0] busy;

    logic [DATA_W-1:0] regs [NR];
    exp_t expq [$];
    logic [NR-1:0] pend;
    bit mov;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rf_rd1 = regs[rf_a1];
    assign rf_rd2 = regs[rf_a2];

    operand_fetch #(.DATA_W(DATA_W), .AW(AW), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .in_ctrl(in_ctrl),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_a(wb_a), .wb_wd(wb_wd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_rd_en(out_rd_en), .out_ctrl(out_ctrl),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value the execute stage should see for a source this cycle.
    function automatic logic [DATA_W-1:0] src_val(input logic [AW-1:0] r, input bit we,
                                                  input logic [AW-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
        if (r == 0) return '0;
        if (we && wa == r) return wd;
        return regs[r];
    endfunction

    // Register still waiting for a write that has not arrived yet.
    function automatic bit waiting(input logic [AW-1:0] r, input bit we, input logic [AW-1:0] wa);
        return (r != 0) && pend[r] && !(we && wa == r);
    endfunction

    // One cycle: drive at posedge+1, check ready, advance model at the edge.
    task automatic step(input bit iv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input bit rde, input logic [CTRL_W-1:0] c,
                        input bit we, input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                        input bit ordy, output bit rdy);
        bit exp_rdy, acc;
        exp_t e;
        in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_en = rde; in_ctrl = c;
        wb_we = we; wb_a = wa; wb_wd = wd; out_ready = ordy;
        #1;
        exp_rdy = !(waiting(r1, we, wa) || waiting(r2, we, wa) || (rde && waiting(rd, we, wa)))
                  && (!mov || ordy);
        chk("in_ready", in_ready, exp_rdy);
        chk("rf_addr", {rf_a1, rf_a2}, {r1, r2});
        rdy = in_ready;
        acc = iv && exp_rdy;
        e.op1 = src_val(r1, we, wa, wd);
        e.op2 = src_val(r2, we, wa, wd);
        e.rd = rd; e.rd_en = rde; e.ctrl = c;
        @(posedge clk);
        if (acc) expq.push_back(e);
        if (acc) mov = 1'b1;
        else if (ordy) mov = 1'b0;
        if (we && wa != 0) begin
            pend[wa] = 1'b0;
            regs[wa] = wd;
        end
        if (acc && rde && rd != 0) pend[rd] = 1'b1;
        #1;
        chk("out_valid", out_valid, mov);
        chk("busy", busy, pend);
    endtask

    // Monitor: compare each transfer to execute and verify holding while stalled.
    initial begin
        exp_t e;
        exp_t prev;
        bit held;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst && held && out_valid)
                chk("hold_stable", {out_op1, out_op2, out_rd, out_rd_en, out_ctrl}, prev);
            if (!rst && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_op1", out_op1, e.op1);
                    chk("out_op2", out_op2, e.op2);
                    chk("out_rd", {out_rd, out_rd_en}, {e.rd, e.rd_en});
                    chk("out_ctrl", out_ctrl, e.ctrl);
                end
            end
            held = !rst && out_valid && !out_ready;
            prev = {out_op1, out_op2, out_rd, out_rd_en, out_ctrl};
        end
    end

    initial begin
        bit r;
        logic [AW-1:0] wa;
        for (int i = 0; i < NR; i++) regs[i] = DATA_W'($urandom);
        regs[0] = '0;
        pend = '0;
        mov = 1'b0;
        rst = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_en = 0; in_ctrl = 0;
        wb_we = 0; wb_a = 0; wb_wd = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {out_op1, out_op2, out_rd, out_rd_en, out_ctrl}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Basic issue: rs1=3, rs2=0, rd=5.
        regs[3] = 16'h1234;
        step(1, 3, 0, 5, 1, 8'hA5, 0, 0, 0, 1, r);
        chk("issue_ready", r, 1);
        // RAW stall on rd=5, then resolved by same-cycle writeback.
        step(1, 5, 0, 6, 1, 8'h11, 0, 0, 0, 1, r);
        chk("raw_stall", r, 0);
        step(1, 5, 0, 6, 1, 8'h11, 1, 5, 16'hBEEF, 1, r);
        chk("raw_bypass", r, 1);
        chk("busy5_clear", busy[5], 0);
        step(0, 0, 0, 0, 0, 0, 1, 6, 16'h0606, 1, r);
        // Back-pressure holds output and blocks input.
        step(1, 1, 2, 9, 1, 8'h22, 0, 0, 0, 1, r);
        step(1, 3, 4, 10, 1, 8'h33, 0, 0, 0, 0, r);
        chk("bp_stall", r, 0);
        step(1, 3, 4, 10, 1, 8'h33, 0, 0, 0, 0, r);
        step(1, 3, 4, 10, 1, 8'h33, 0, 0, 0, 1, r);
        chk("bp_release", r, 1);
        // WAW: stall without writeback, accept with writeback to rd.
        step(1, 0, 0, 7, 1, 8'h44, 0, 0, 0, 1, r);
        step(1, 0, 0, 7, 1, 8'h55, 0, 0, 0, 1, r);
        chk("waw_stall", r, 0);
        step(1, 0, 0, 7, 1, 8'h55, 1, 7, 16'h7777, 1, r);
        chk("waw_accept", r, 1);
        chk("busy7_kept", busy[7], 1);
        // Writeback to register 0 is never bypassed.
        step(1, 0, 0, 0, 1, 8'h66, 1, 0, 16'hFFFF, 1, r);
        chk("busy0", busy[0], 0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            wa = AW'($urandom_range(0, 7));
            if (pend != 0 && ($urandom % 2) == 0) begin
                int s;
                s = $urandom_range(0, NR - 1);
                for (int k = 0; k < NR; k++)
                    if (pend[(s + k) % NR]) wa = AW'((s + k) % NR);
            end
            step(($urandom % 4) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), ($urandom % 4) != 0, CTRL_W'($urandom),
                 ($urandom % 2) == 0, wa, DATA_W'($urandom), ($urandom % 4) != 0, r);
        end

        // Drain, then build busy=0x24 with a held output and reset mid-cycle.
        for (int i = 1; i < NR; i++)
            if (pend[i]) step(0, 0, 0, 0, 0, 0, 1, AW'(i), DATA_W'($urandom), 1, r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        step(1, 0, 0, 2, 1, 8'h77, 0, 0, 0, 1, r);
        step(1, 0, 0, 5, 1, 8'h88, 0, 0, 0, 1, r);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
        chk("pre_rst_busy", busy, 32'h0000_0024);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_outs", {out_op1, out_op2, out_rd, out_rd_en, out_ctrl}, 0);
        expq.delete();
        pend = '0;
        mov = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 2, 5, 3, 1, 8'h99, 0, 0, 0, 1, r);
        chk("post_rst_ready", r, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        chk("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
